// File: rtl/ram_arbiter_2req.sv
// Round-robin arbiter/sequencer sharing one single-port RAM (synchronous
// write, combinational read) between two requesters.
//
// Handshake: a requester raises req with we/addr/din and holds all four
// stable until it sees its one-cycle ack; it may drop or change them at the
// edge that ends the ack cycle. The owner is masked from arbitration during
// its own ack cycle, so the next grant there can only go to the other side.
//
// Timing per grant sampled at edge N: ACCESS in cycle N..N+1 (RAM port
// carries the command, write commits at N+1), RESP in cycle N+1..N+2
// (ack and rdata valid). All outputs are registers.
module ram_arbiter_2req #(
  parameter int addr_width = 2,
  parameter int data_width = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [addr_width-1:0] addr0,
  input  logic [data_width-1:0] din0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] din1,
  output logic                  ack1,
  output logic [data_width-1:0] rdata,
  output logic                  busy,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  last_grant;
  logic                  last_grant_next;
  logic                  owner;
  logic                  owner_next;
  logic                  ram_we_next;
  logic [addr_width-1:0] ram_addr_next;
  logic [data_width-1:0] ram_din_next;
  logic                  ack0_next;
  logic                  ack1_next;
  logic [data_width-1:0] rdata_next;
  logic                  busy_next;

  logic                  grant_valid;
  logic                  grant_id;

  // Winner selection: in IDLE both requesters compete (tie goes to the one
  // that did not win last); in RESP only the non-owner may be granted.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          grant_valid = 1'b1;
          grant_id    = ~last_grant;
        end else if (req0) begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end else if (req1) begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end
      end
      RESP: begin
        if (!owner && req1) begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end else if (owner && req0) begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end
      end
      default: begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
      end
    endcase
  end

  // Next-state and next-output logic; RAM port fields hold unless a grant
  // loads them, ram_we and acks default low so each is a single-cycle pulse.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    owner_next      = owner;
    ram_we_next     = 1'b0;
    ram_addr_next   = ram_addr;
    ram_din_next    = ram_din;
    ack0_next       = 1'b0;
    ack1_next       = 1'b0;
    rdata_next      = rdata;

    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // Reads capture the combinational RAM output; writes leave rdata.
        if (!ram_we) begin
          rdata_next = ram_dout;
        end
        ack0_next  = ~owner;
        ack1_next  = owner;
        state_next = RESP;
      end
      RESP: begin
        state_next = grant_valid ? ACCESS : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (grant_valid) begin
      owner_next      = grant_id;
      last_grant_next = grant_id;
      ram_we_next     = grant_id ? we1 : we0;
      ram_addr_next   = grant_id ? addr1 : addr0;
      ram_din_next    = grant_id ? din1 : din0;
    end

    busy_next = (state_next != IDLE);
  end

  // State and output registers; reset clears everything at once, which also
  // aborts an in-flight write before its commit edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      owner      <= owner_next;
      ram_we     <= ram_we_next;
      ram_addr   <= ram_addr_next;
      ram_din    <= ram_din_next;
      ack0       <= ack0_next;
      ack1       <= ack1_next;
      rdata      <= rdata_next;
      busy       <= busy_next;
    end
  end

endmodule
